// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transfer buffer.
//   txState_t : TX handshake FSM states
//   rxState_t : RX fetch FSM states
//   rxEntry_t : one RX FIFO entry (error flag + byte)
//   RX_RDY / RX_ERR : bit positions inside RxStatus
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } txState_t;

  typedef enum logic {
    RX_IDLE,
    RX_WAIT_CLR
  } rxState_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rxEntry_t;

  localparam int RX_RDY = 0;
  localparam int RX_ERR = 1;

  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int DEF_TIMEOUT    = 65535;
  localparam int DEF_TO_W       = 16;

endpackage

// File: rtl/uart_xfer_buf_if.sv
// Handshake bundle between the transfer buffer and the uart_io stage.
//   TxStart  : one-cycle start pulse, buffer -> uart_io
//   TxData   : byte to send, stable from TxStart until TxStatus falls
//   TxStatus : transmitter busy, uart_io -> buffer
//   RxFetch  : one-cycle acknowledge of a received byte, buffer -> uart_io
//   RxData   : received byte, uart_io -> buffer
//   RxStatus : [0] byte ready, [1] error with that byte
// master = buffer side, slave = uart_io side.
interface uart_xfer_buf_if;
  logic       TxStart;
  logic [7:0] TxData;
  logic       TxStatus;
  logic       RxFetch;
  logic [7:0] RxData;
  logic [1:0] RxStatus;

  modport master (
    output TxStart, TxData, RxFetch,
    input  TxStatus, RxData, RxStatus
  );

  modport slave (
    input  TxStart, TxData, RxFetch,
    output TxStatus, RxData, RxStatus
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO.
//   RSClk, Reset : clock, async active-high reset (clears pointers)
//   wrEn, wrData : push; accepted when not full, or when full and popping
//   rdEn         : pop; ignored while empty
//   rdData       : head entry, forced to zero while empty
//   full, empty  : status from (DEPTH_LOG2+1)-bit pointers
//   level        : occupancy = wrPtr - rdPtr
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                RSClk,
  input  logic                Reset,
  input  logic                wrEn,
  input  logic [WIDTH-1:0]    wrData,
  input  logic                rdEn,
  output logic [WIDTH-1:0]    rdData,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wrPtr, rdPtr;
  logic                doWr, doRd;

  // Same index with differing wrap bits means the write side has lapped.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) &&
                 (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
  assign level = wrPtr - rdPtr;

  // A pop frees the slot the simultaneous push lands in, so full+pop accepts.
  assign doRd = rdEn && !empty;
  assign doWr = wrEn && (!full || doRd);

  always_ff @(posedge RSClk or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge RSClk) begin
    if (doWr) mem[wrPtr[DEPTH_LOG2-1:0]] <= wrData;
  end

  // Storage is not reset; masking keeps the head at zero when nothing is queued.
  assign rdData = empty ? '0 : mem[rdPtr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_xfer_buf.sv
// Byte-stream buffer between the host side and uart_io.
//   Host TX : TxWrEn/TxWrData push, TxFull, TxLevel
//   Host RX : RxRdEn pop, RxRdData/RxRdErr show-ahead head, RxEmpty, RxLevel
//   Errors  : TxTimeoutErr, RxOverflowErr sticky, ErrClr clears (set wins)
//   io      : handshake to uart_io (TxStart/TxData/TxStatus, RxFetch/RxData/RxStatus)
// TX FIFO drains one byte per TxStart/TxStatus handshake; the RX side polls
// RxStatus and acks each captured byte with RxFetch.
module uart_xfer_buf
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int TO_W       = DEF_TO_W
) (
  input  logic                RSClk,
  input  logic                Reset,
  input  logic                TxWrEn,
  input  logic [7:0]          TxWrData,
  output logic                TxFull,
  output logic [DEPTH_LOG2:0] TxLevel,
  input  logic                RxRdEn,
  output logic [7:0]          RxRdData,
  output logic                RxRdErr,
  output logic                RxEmpty,
  output logic [DEPTH_LOG2:0] RxLevel,
  input  logic                ErrClr,
  output logic                TxTimeoutErr,
  output logic                RxOverflowErr,
  uart_xfer_buf_if.master     io
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // ---------------- TX path ----------------
  txState_t        txState;
  logic [TO_W-1:0] toCnt;
  logic            txEmpty, txPop, txToHit;
  logic [7:0]      txHead;

  uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) txFifo (
    .RSClk  (RSClk),
    .Reset  (Reset),
    .wrEn   (TxWrEn),
    .wrData (TxWrData),
    .rdEn   (txPop),
    .rdData (txHead),
    .full   (TxFull),
    .empty  (txEmpty),
    .level  (TxLevel)
  );

  assign txPop   = (txState == TX_IDLE) && !txEmpty && !io.TxStatus;
  // Counter is cleared in START, so this fires TIMEOUT cycles into WAIT_BUSY.
  assign txToHit = (txState == TX_WAIT_BUSY) && !io.TxStatus && (toCnt == TO_LAST);

  always_ff @(posedge RSClk or posedge Reset) begin
    if (Reset) begin
      txState      <= TX_IDLE;
      toCnt        <= '0;
      io.TxStart   <= 1'b0;
      io.TxData    <= 8'h00;
      TxTimeoutErr <= 1'b0;
    end else begin
      io.TxStart <= 1'b0;
      case (txState)
        TX_IDLE: begin
          if (txPop) begin
            io.TxData  <= txHead;
            io.TxStart <= 1'b1;
            txState    <= TX_START;
          end
        end
        TX_START: begin
          toCnt   <= '0;
          txState <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (io.TxStatus)  txState <= TX_WAIT_DONE;
          else if (txToHit) txState <= TX_IDLE;  // byte is abandoned
          else              toCnt   <= toCnt + TO_W'(1);
        end
        TX_WAIT_DONE: begin
          if (!io.TxStatus) txState <= TX_IDLE;
        end
        default: txState <= TX_IDLE;
      endcase

      if (txToHit)     TxTimeoutErr <= 1'b1;
      else if (ErrClr) TxTimeoutErr <= 1'b0;
    end
  end

  // ---------------- RX path ----------------
  rxState_t rxState;
  rxEntry_t rxHold, rxHead;
  logic     rxFull, rxCap;

  // The captured entry is written on the edge that ends the RxFetch pulse,
  // so RxFetch doubles as the FIFO write strobe.
  uart_sync_fifo #(.WIDTH($bits(rxEntry_t)), .DEPTH_LOG2(DEPTH_LOG2)) rxFifo (
    .RSClk  (RSClk),
    .Reset  (Reset),
    .wrEn   (io.RxFetch),
    .wrData (rxHold),
    .rdEn   (RxRdEn),
    .rdData (rxHead),
    .full   (rxFull),
    .empty  (RxEmpty),
    .level  (RxLevel)
  );

  assign RxRdData = rxHead.data;
  assign RxRdErr  = rxHead.err;

  // Full FIFO withholds the fetch; uart_io keeps the byte and flags any loss later.
  // A pending write has always landed before IDLE is re-entered.
  assign rxCap = (rxState == RX_IDLE) && io.RxStatus[RX_RDY] && !rxFull;

  always_ff @(posedge RSClk or posedge Reset) begin
    if (Reset) begin
      rxState       <= RX_IDLE;
      rxHold        <= '0;
      io.RxFetch    <= 1'b0;
      RxOverflowErr <= 1'b0;
    end else begin
      io.RxFetch <= 1'b0;
      case (rxState)
        RX_IDLE: begin
          if (rxCap) begin
            rxHold.err  <= io.RxStatus[RX_ERR];
            rxHold.data <= io.RxData;
            io.RxFetch  <= 1'b1;
            rxState     <= RX_WAIT_CLR;
          end
        end
        RX_WAIT_CLR: begin
          if (!io.RxStatus[RX_RDY]) rxState <= RX_IDLE;
        end
        default: rxState <= RX_IDLE;
      endcase

      if (rxCap && io.RxStatus[RX_ERR]) RxOverflowErr <= 1'b1;
      else if (ErrClr)                  RxOverflowErr <= 1'b0;
    end
  end

endmodule
